// File: rtl/imem_loader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// imem_loader : byte-addressed instruction memory, stream loader, core reset
// Revision    : 1.0
// ----------------------------------------------------------------------------
module imem_loader #(
   parameter int DEPTH_BYTES    = 256,
   parameter int ADDR_W         = 8,
   parameter int BYTES_PER_WORD = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        load_start,
   input  logic [ADDR_W:0]             load_len,
   input  logic                        in_valid,
   input  logic [7:0]                  in_byte,
   output logic                        in_ready,
   output logic                        load_done,
   output logic                        load_err,
   output logic                        core_reset,
   input  logic [ADDR_W-1:0]           fetch_addr,
   output logic [8*BYTES_PER_WORD-1:0] fetch_instr,
   output logic                        fetch_misaligned
);

   localparam logic [ADDR_W:0]   MAX_LEN  = (ADDR_W+1)'(DEPTH_BYTES);
   localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(BYTES_PER_WORD - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2
   } state_t;

   state_t                        state;
   logic [ADDR_W-1:0]             wr_ptr;
   logic [ADDR_W:0]               byte_cnt;
   logic [ADDR_W:0]               len;
   logic [7:0]                    mem [DEPTH_BYTES];
   logic                          len_ok;
   logic                          accept;
   logic [8*BYTES_PER_WORD-1:0]   word;

   assign len_ok = (load_len != '0) && (load_len <= MAX_LEN);
   assign accept = in_ready && in_valid;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         wr_ptr     <= '0;
         byte_cnt   <= '0;
         len        <= '0;
         core_reset <= 1'b1;
         in_ready   <= 1'b0;
         load_done  <= 1'b0;
         load_err   <= 1'b0;
      end else begin
         load_done <= 1'b0;
         load_err  <= 1'b0;
         case (state)
            IDLE, RUN: begin
               if (load_start) begin
                  if (len_ok) begin
                     // core_reset and in_ready rise together so the core never sees a partial image
                     state      <= LOAD;
                     len        <= load_len;
                     wr_ptr     <= '0;
                     byte_cnt   <= '0;
                     core_reset <= 1'b1;
                     in_ready   <= 1'b1;
                  end else begin
                     load_err   <= 1'b1;
                     state      <= IDLE;
                     core_reset <= 1'b1;
                  end
               end
            end
            LOAD: begin
               if (accept) begin
                  wr_ptr   <= wr_ptr + PTR_ONE;
                  byte_cnt <= byte_cnt + CNT_ONE;
                  if (byte_cnt + CNT_ONE == len) begin
                     state      <= RUN;
                     load_done  <= 1'b1;
                     in_ready   <= 1'b0;
                     core_reset <= 1'b0;
                  end
               end
            end
            default: begin
               state      <= IDLE;
               core_reset <= 1'b1;
               in_ready   <= 1'b0;
            end
         endcase
      end
   end

   // Reset must also block the write of a byte offered in the reset cycle.
   always_ff @(posedge clk) begin
      if (accept && !reset) begin
         mem[wr_ptr] <= in_byte;
      end
   end

   // Big-endian assembly; the ADDR_W-bit sum wraps modulo DEPTH_BYTES.
   always_comb begin
      word = '0;
      for (int i = 0; i < BYTES_PER_WORD; i++) begin
         word[8*(BYTES_PER_WORD-1-i) +: 8] = mem[fetch_addr + ADDR_W'(i)];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_instr      <= '0;
         fetch_misaligned <= 1'b0;
      end else begin
         fetch_instr      <= word;
         fetch_misaligned <= (fetch_addr & OFF_MASK) != '0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_imem_loader : directed stimulus with queue scoreboard for imem_loader
// Revision       : 1.0
// ----------------------------------------------------------------------------
module tb_imem_loader;

   localparam int DEPTH = 256;
   localparam int AW    = 8;
   localparam int BPW   = 4;

   logic             clk        = 1'b0;
   logic             reset      = 1'b1;
   logic             load_start = 1'b0;
   logic [AW:0]      load_len   = '0;
   logic             in_valid   = 1'b0;
   logic [7:0]       in_byte    = '0;
   logic             in_ready;
   logic             load_done;
   logic             load_err;
   logic             core_reset;
   logic [AW-1:0]    fetch_addr = '0;
   logic [8*BPW-1:0] fetch_instr;
   logic             fetch_misaligned;

   imem_loader #(
      .DEPTH_BYTES    (DEPTH),
      .ADDR_W         (AW),
      .BYTES_PER_WORD (BPW)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .load_start       (load_start),
      .load_len         (load_len),
      .in_valid         (in_valid),
      .in_byte          (in_byte),
      .in_ready         (in_ready),
      .load_done        (load_done),
      .load_err         (load_err),
      .core_reset       (core_reset),
      .fetch_addr       (fetch_addr),
      .fetch_instr      (fetch_instr),
      .fetch_misaligned (fetch_misaligned)
   );

   always #5 clk = ~clk;

   typedef struct {bit is_err; int cyc;} ev_t;
   typedef struct {logic [31:0] word; logic mis;} fx_t;

   ev_t        ev_q[$];
   fx_t        fx_q[$];
   int         cyc        = 0;
   int         n_chk      = 0;
   int         n_fail     = 0;
   logic       fetch_chk  = 1'b0;
   logic       fetch_pend = 1'b0;
   logic [7:0] prog [4]   = '{8'h20, 8'h0a, 8'h00, 8'h0a};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge clk) begin
      cyc        <= cyc + 1;
      fetch_pend <= fetch_chk;
   end

   // Monitor: pops an expectation whenever the DUT presents a pulse or a fetch result.
   always @(negedge clk) begin
      ev_t e;
      fx_t f;
      if (load_done || load_err) begin
         if (ev_q.size() == 0) begin
            check(load_done ? "unexpected load_done" : "unexpected load_err", 32'd1, 32'd0);
         end else begin
            e = ev_q.pop_front();
            check("pulse kind load_err", 32'(load_err), 32'(e.is_err));
            check("pulse cycle", 32'(cyc), 32'(e.cyc));
         end
      end
      if (fetch_pend) begin
         if (fx_q.size() == 0) begin
            check("fetch without expectation", 32'd1, 32'd0);
         end else begin
            f = fx_q.pop_front();
            check("fetch_instr", fetch_instr, f.word);
            check("fetch_misaligned", 32'(fetch_misaligned), 32'(f.mis));
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      reset      = 1'b1;
      load_start = 1'b0;
      in_valid   = 1'b0;
      fetch_chk  = 1'b0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic start(input int len);
      load_start = 1'b1;
      load_len   = (AW+1)'(len);
      if (len < 1 || len > DEPTH) ev_q.push_back('{1'b1, cyc + 1});
      tick();
      load_start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit last);
      in_valid = 1'b1;
      in_byte  = b;
      if (last) ev_q.push_back('{1'b0, cyc + 1});
      tick();
      in_valid = 1'b0;
   endtask

   task automatic fetch(input logic [AW-1:0] a, input logic [31:0] w, input logic m);
      fetch_addr = a;
      fetch_chk  = 1'b1;
      fx_q.push_back('{w, m});
      tick();
      fetch_chk = 1'b0;
   endtask

   task automatic check_ctl(input string tag, input logic cr, input logic rdy);
      check({tag, " core_reset"}, 32'(core_reset), 32'(cr));
      check({tag, " in_ready"}, 32'(in_ready), 32'(rdy));
   endtask

   initial begin
      // Reset values
      do_reset();
      check_ctl("reset", 1'b1, 1'b0);
      check("reset load_done", 32'(load_done), 32'd0);
      check("reset load_err", 32'(load_err), 32'd0);
      check("reset fetch_instr", fetch_instr, 32'h0);
      check("reset fetch_misaligned", 32'(fetch_misaligned), 32'd0);

      // Basic 4-byte load
      start(4);
      check_ctl("load1 start", 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) send_byte(prog[i], i == 3);
      check_ctl("load1 run", 1'b0, 1'b0);
      fetch(8'h00, 32'h200a000a, 1'b0);

      // Same bytes with in_valid stalls
      do_reset();
      start(4);
      for (int i = 0; i < 4; i++) begin
         send_byte(prog[i], i == 3);
         if (i < 3) begin
            tick();
            check_ctl("stall", 1'b1, 1'b1);
         end
      end
      check_ctl("stall run", 1'b0, 1'b0);
      fetch(8'h00, 32'h200a000a, 1'b0);

      // Illegal lengths from IDLE
      do_reset();
      start(0);
      check_ctl("len0", 1'b1, 1'b0);
      start(257);
      check_ctl("len257", 1'b1, 1'b0);

      // Full-memory load with wrapping fetches
      start(256);
      for (int i = 0; i < 256; i++) send_byte(8'(i), i == 255);
      check_ctl("full run", 1'b0, 1'b0);
      fetch(8'hFE, 32'hFEFF0001, 1'b1);
      fetch(8'h10, 32'h10111213, 1'b0);
      fetch(8'hFC, 32'hFCFDFEFF, 1'b0);

      // RUN -> LOAD reload, then 2-byte overlay with read-first check
      start(4);
      check_ctl("reload", 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) send_byte(prog[i], i == 3);
      start(2);
      check_ctl("overlay start", 1'b1, 1'b1);
      fetch_addr = 8'h00;
      fetch_chk  = 1'b1;
      fx_q.push_back('{32'h200a000a, 1'b0});
      send_byte(8'hAA, 1'b0);
      fetch_chk = 1'b0;
      send_byte(8'hBB, 1'b1);
      fetch(8'h00, 32'hAABB000a, 1'b0);
      fetch(8'hFE, 32'hFEFFAABB, 1'b1);

      // Illegal length while running drops back to IDLE
      start(300);
      check_ctl("run illegal", 1'b1, 1'b0);
      fetch(8'h00, 32'hAABB000a, 1'b0);

      // Reset mid-load; reset also wins over load_start and in_valid
      start(4);
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      reset      = 1'b1;
      in_valid   = 1'b1;
      in_byte    = 8'h33;
      load_start = 1'b1;
      load_len   = 9'd4;
      tick();
      reset      = 1'b0;
      in_valid   = 1'b0;
      load_start = 1'b0;
      check_ctl("abort", 1'b1, 1'b0);
      tick();
      tick();
      check_ctl("abort idle", 1'b1, 1'b0);
      fetch(8'h00, 32'h1122000a, 1'b0);
      start(4);
      for (int i = 0; i < 4; i++) send_byte(8'(i + 1), i == 3);
      check_ctl("after abort", 1'b0, 1'b0);
      fetch(8'h00, 32'h01020304, 1'b0);

      repeat (3) tick();
      check("pulse expectations drained", 32'(ev_q.size()), 32'd0);
      check("fetch expectations drained", 32'(fx_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
